memory_ctrl: RTL and testbench

On-chip storage block holding the double-buffered modulation table and the normal (per-transducer drive) table. The host CPU bus writes both tables. The modulation sampler reads its table through a byte-wide port, and the normal-mode drive path reads its table through a word-wide port. Both read ports are registered, fixed-latency pipelines.

---
 rtl/memory_ctrl.sv | 76 +++++++
 tb/tb_memory_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// Host-written modulation (two byte pages) and normal (two word segments) tables
// with two-stage registered, read-first read ports for the sampler and drive path.
module memory_ctrl #(
  parameter int unsigned MOD_SIZE     = 32768,
  parameter int unsigned NORMAL_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BUS_EN,
  input  logic        BUS_WE,
  input  logic [1:0]  BUS_SEL,
  input  logic [14:0] BUS_ADDR,
  input  logic [15:0] BUS_DATA_IN,
  input  logic [14:0] MOD_ADDR,
  input  logic        MOD_PAGE,
  output logic [7:0]  MOD_VALUE,
  input  logic [7:0]  NORMAL_ADDR,
  input  logic        NORMAL_SEGMENT,
  output logic [15:0] NORMAL_VALUE
);

  localparam int unsigned MOD_WORDS  = MOD_SIZE / 2;
  localparam int unsigned MOD_ENTRY  = 2 * MOD_WORDS;
  localparam int unsigned NORM_ENTRY = 2 * NORMAL_DEPTH;
  localparam logic [1:0]  SEL_MOD    = 2'b01;
  localparam logic [1:0]  SEL_NORMAL = 2'b10;

  // Modulation pages held as 16-bit words: {page, word} indexes both byte lanes at once.
  logic [15:0] mod_mem  [MOD_ENTRY];
  logic [15:0] norm_mem [NORM_ENTRY];

  logic        mod_we_c;
  logic        norm_we_c;
  logic [15:0] mod_word_q;
  logic        mod_lsb_q;
  logic [15:0] norm_word_q;

  // Writes coincident with reset are dropped.
  assign mod_we_c  = BUS_EN & BUS_WE & ~RST & (BUS_SEL == SEL_MOD);
  assign norm_we_c = BUS_EN & BUS_WE & ~RST & (BUS_SEL == SEL_NORMAL);

  // Storage arrays: never reset, contents persist across RST.
  always_ff @(posedge CLK) begin
    if (mod_we_c) begin
      mod_mem[BUS_ADDR[14:0]] <= BUS_DATA_IN;
    end
    if (norm_we_c) begin
      norm_mem[BUS_ADDR[8:0]] <= BUS_DATA_IN;
    end
  end

  // Stage 1 reads the array in the same edge as any write, so collisions return old data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mod_word_q  <= '0;
      mod_lsb_q   <= 1'b0;
      norm_word_q <= '0;
    end else begin
      mod_word_q  <= mod_mem[{MOD_PAGE, MOD_ADDR[14:1]}];
      mod_lsb_q   <= MOD_ADDR[0];
      norm_word_q <= norm_mem[{NORMAL_SEGMENT, NORMAL_ADDR}];
    end
  end

  // Stage 2: byte-lane select and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MOD_VALUE    <= '0;
      NORMAL_VALUE <= '0;
    end else begin
      MOD_VALUE    <= mod_lsb_q ? mod_word_q[15:8] : mod_word_q[7:0];
      NORMAL_VALUE <= norm_word_q;
    end
  end

endmodule

// File: tb/tb_memory_ctrl.sv
// Randomized scoreboard bench for memory_ctrl against a byte/word-addressed table model.
module tb_memory_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        BUS_EN = 1'b0;
  logic        BUS_WE = 1'b0;
  logic [1:0]  BUS_SEL = 2'b00;
  logic [14:0] BUS_ADDR = '0;
  logic [15:0] BUS_DATA_IN = '0;
  logic [14:0] MOD_ADDR = '0;
  logic        MOD_PAGE = 1'b0;
  logic [7:0]  MOD_VALUE;
  logic [7:0]  NORMAL_ADDR = '0;
  logic        NORMAL_SEGMENT = 1'b0;
  logic [15:0] NORMAL_VALUE;

  memory_ctrl dut (
    .CLK(CLK), .RST(RST),
    .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_SEL(BUS_SEL),
    .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN),
    .MOD_ADDR(MOD_ADDR), .MOD_PAGE(MOD_PAGE), .MOD_VALUE(MOD_VALUE),
    .NORMAL_ADDR(NORMAL_ADDR), .NORMAL_SEGMENT(NORMAL_SEGMENT),
    .NORMAL_VALUE(NORMAL_VALUE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: page[p][byte], seg[s][index]
  logic [7:0]  mod_m  [0:1][0:32767];
  logic [15:0] norm_m [0:1][0:255];

  typedef struct {
    int          due;
    bit          cm;
    logic [7:0]  em;
    bit          cn;
    logic [15:0] en;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int passes = 0;

  task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: MOD_VALUE got %02h want %02h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic check16(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: NORMAL_VALUE got %04h want %04h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Monitor: results are due two edges after the address was driven.
  always @(negedge CLK) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++;
      $display("FAIL %s: result due at cycle %0d never compared (now %0d)", sbq[0].tag, sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.cm) check8(e.tag, MOD_VALUE, e.em);
      if (e.cn) check16(e.tag, NORMAL_VALUE, e.en);
    end
  end

  // One clock of stimulus; expectations are taken before this cycle's write lands.
  task automatic drive(input bit en, input bit we, input logic [1:0] sel,
                       input logic [14:0] ba, input logic [15:0] bd,
                       input logic [14:0] ma, input bit mp, input bit cm,
                       input logic [7:0] na, input bit ns, input bit cn,
                       input string tag);
    exp_t e;
    int w;
    @(posedge CLK);
    #1;
    if (cm || cn) begin
      e.due = cyc + 2;
      e.cm  = cm;
      e.em  = cm ? mod_m[mp][ma] : 8'h00;
      e.cn  = cn;
      e.en  = cn ? norm_m[ns][na] : 16'h0000;
      e.tag = tag;
      sbq.push_back(e);
    end
    BUS_EN = en; BUS_WE = we; BUS_SEL = sel; BUS_ADDR = ba; BUS_DATA_IN = bd;
    MOD_ADDR = ma; MOD_PAGE = mp; NORMAL_ADDR = na; NORMAL_SEGMENT = ns;
    if (en && we && !RST) begin
      if (sel == 2'b01) begin
        w = int'(ba[13:0]);
        mod_m[ba[14]][2*w]     = bd[7:0];
        mod_m[ba[14]][2*w + 1] = bd[15:8];
      end else if (sel == 2'b10) begin
        norm_m[ba[8]][ba[7:0]] = bd;
      end
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [14:0] ba, input logic [15:0] bd);
    drive(1'b1, 1'b1, sel, ba, bd, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "wr");
  endtask

  task automatic rd(input logic [14:0] ma, input bit mp, input logic [7:0] na, input bit ns,
                    input string tag);
    drive(1'b0, 1'b0, 2'b00, '0, '0, ma, mp, 1'b1, na, ns, 1'b1, tag);
  endtask

  task automatic sweep(input bit mp, input int start, input int n, input string tag);
    for (int i = 0; i < n; i++)
      rd(15'((start + i) % 32768), mp, 8'($urandom), 1'($urandom), tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check8("reset_mod", MOD_VALUE, 8'h00);
    check16("reset_norm", NORMAL_VALUE, 16'h0000);
    @(posedge CLK);
    #1 RST = 1'b0;

    // Fill both modulation pages and both normal segments with random data.
    for (int w = 0; w < 32768; w++) wr(2'b01, 15'(w), 16'($urandom));
    for (int i = 0; i < 512; i++) wr(2'b10, 15'(i), 16'($urandom));

    // Incrementing sweeps across the 32767 -> 0 wrap on each page.
    sweep(1'b0, 32768 - 2048, 4096, "sweep_p0");
    sweep(1'b1, 32768 - 2048, 4096, "sweep_p1");

    // Byte-lane placement of a host word.
    wr(2'b01, 15'h0005, 16'h1234);
    rd(15'd10, 1'b0, 8'd0, 1'b0, "bytes_lo");
    rd(15'd11, 1'b0, 8'd0, 1'b0, "bytes_hi");

    // Page toggle with MOD_ADDR held at 7.
    wr(2'b01, 15'h0003, 16'hAA11);
    wr(2'b01, 15'h4003, 16'h5522);
    for (int i = 0; i < 8; i++) rd(15'd7, (i >= 4), 8'd248, 1'b0, "page_toggle");

    // Normal segment 1, entry 248; segment 0 entry 248 untouched.
    wr(2'b10, 15'h01F8, 16'hBEEF);
    rd(15'd0, 1'b0, 8'd248, 1'b1, "norm_seg1_248");
    rd(15'd0, 1'b0, 8'd248, 1'b0, "norm_seg0_248");

    // Ignored host accesses: bad select, or strobe without write enable.
    drive(1'b1, 1'b1, 2'b00, 15'h0020, 16'hA5A5, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ign");
    drive(1'b1, 1'b1, 2'b11, 15'h0020, 16'h5A5A, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ign");
    drive(1'b1, 1'b0, 2'b01, 15'h0021, 16'hC3C3, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ign");
    drive(1'b1, 1'b0, 2'b10, 15'h0040, 16'h3C3C, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ign");
    drive(1'b1, 1'b1, 2'b11, 15'h0140, 16'h6969, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "ign");
    for (int b = 64; b < 68; b++) rd(15'(b), 1'b0, 8'h20, 1'b0, "ignored_wr");
    rd(15'd64, 1'b1, 8'h40, 1'b0, "ignored_wr");
    rd(15'd65, 1'b1, 8'h40, 1'b1, "ignored_wr");

    // Random traffic with concurrent writes; some cycles read the word being written.
    for (int i = 0; i < 3000; i++) begin
      logic [14:0] ba;
      logic [1:0]  sel;
      logic [14:0] ma;
      logic [7:0]  na;
      bit mp, ns, en, we;
      ba  = 15'($urandom);
      sel = 2'($urandom);
      en  = 1'($urandom);
      we  = ($urandom_range(0, 3) != 0);
      ma  = 15'($urandom);
      mp  = 1'($urandom);
      na  = 8'($urandom);
      ns  = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b1; we = 1'b1; sel = 2'b01;
        ma = {ba[13:0], 1'($urandom)};
        mp = ba[14];
      end else if ($urandom_range(0, 5) == 0) begin
        en = 1'b1; we = 1'b1; sel = 2'b10;
        na = ba[7:0];
        ns = ba[8];
      end
      drive(en, we, sel, ba, 16'($urandom), ma, mp, 1'b1, na, ns, 1'b1, "random");
    end

    // Reset in the middle of a sweep, with a host write held during reset.
    sweep(1'b0, 100, 300, "pre_reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    sbq.delete();
    BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_SEL = 2'b01;
    BUS_ADDR = 15'h0100; BUS_DATA_IN = 16'hDEAD;
    #1;
    check8("rst_async_mod", MOD_VALUE, 8'h00);
    check16("rst_async_norm", NORMAL_VALUE, 16'h0000);
    @(posedge CLK);
    #1;
    check8("rst_hold_mod", MOD_VALUE, 8'h00);
    check16("rst_hold_norm", NORMAL_VALUE, 16'h0000);
    RST = 1'b0;
    BUS_EN = 1'b0; BUS_WE = 1'b0;
    rd(15'h0200, 1'b0, 8'h00, 1'b1, "rst_dropped_wr");
    rd(15'h0201, 1'b0, 8'h00, 1'b1, "rst_dropped_wr");
    sweep(1'b0, 400, 300, "post_reset");
    sweep(1'b1, 32700, 200, "post_reset_p1");

    repeat (4) drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "idle");
    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL drain: %0d results outstanding, want 0", sbq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
